rom_bank_ctrl: RTL and testbench
================================

Name: rom_bank_ctrl

Overview:
Parametrised successor to the single-chip 23128 ROM controller. It emulates NUM_CHIPS EPROM sockets sharing one CPU-side address/OE bus and maps them onto one synchronous external memory port with a req/ack handshake. It adds:
- wait-state generation to the CPU;
- a one-entry last-read cache;
- an access timeout;
- sticky error flags.

It sits between the CPU bus decode and the board memory arbiter.

Parameters:
ADDR_W, 14, per-chip address width (14 = 16K x 8 part)
DATA_W, 8, data width
NUM_CHIPS, 4, number of emulated ROM sockets (power of two, >=2)
CHIP_W, $clog2(NUM_CHIPS), chip index width (derived, not overridden)
MAX_WAIT, 15, cycles without mem_ack before a timeout
FILL, all ones, data returned on timeout (open-bus value)

Ports:
clk  in  1  system clock
rst_b  in  1  asynchronous active-low reset
A  in  ADDR_W  CPU address within chip
CE_b  in  NUM_CHIPS  per-chip enable, active low
OE_b  in  1  output enable, active low
inval  in  1  invalidate cache entry (ROM image reloaded)
clr_err  in  1  clear sticky error flags
D  out  DATA_W  read data; 0 when D_oe low
D_oe  out  1  drive enable for top-level tristate
rdy  out  1  data valid / end of wait state to CPU
mem_req  out  1  external read request (level)
mem_addr  out  CHIP_W+ADDR_W  {chip_idx, A}
mem_ack  in  1  single-cycle acknowledge, data valid same cycle
mem_rdata  in  DATA_W  external read data
multi_sel_err  out  1  sticky: more than one CE_b low during OE_b low
timeout_err  out  1  sticky: access timed out

Behaviour:
- All CPU inputs are synchronous to clk; there are no synchronisers in this block.
- sel_valid = ~OE_b & exactly one CE_b bit low. chip_idx is the encoded index of that bit.
- Reset (async, rst_b low) forces:
  - state IDLE;
  - D=0, D_oe=0, rdy=0, mem_req=0, mem_addr=0;
  - cache invalid;
  - both sticky errors 0.
  Reset during WAIT drops mem_req immediately. A late mem_ack after reset is ignored.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - If sel_valid and cache hit (valid & tag=={chip_idx,A}) and inval low: load data_reg from cache and go to HOLD. rdy is seen 1 cycle after the select.
  - If sel_valid otherwise: register mem_addr={chip_idx,A}, set mem_req=1, clear wait_cnt, go to WAIT.
  - If ~OE_b with two or more CE_b low: set multi_sel_err and stay in IDLE. No memory access is made.
- WAIT:
  - mem_req holds 1 and mem_addr is stable.
  - On mem_ack: data_reg<=mem_rdata, cache<={valid,tag,data}, mem_req<=0, go to HOLD. Minimum miss latency is 2 cycles from select to rdy (ack in the first WAIT cycle).
  - On wait_cnt==MAX_WAIT-1 with no ack: mem_req<=0, data_reg<=FILL, timeout_err<=1, cache is not updated, go to HOLD.
  - The CPU deselecting during WAIT does not abort the transaction. The access completes (cache is filled) and HOLD exits on the next cycle.
- HOLD:
  - rdy=1, D_oe=1, D=data_reg.
  - Exit to IDLE (rdy, D_oe low next cycle) when sel_valid drops, chip_idx changes, or A changes. A new access is evaluated from IDLE, so back-to-back different addresses cost 1 idle cycle.
- mem_ack outside WAIT is ignored.
- inval clears cache valid on the next edge. If inval and a hit lookup occur in the same cycle, inval wins and the access is treated as a miss.
- clr_err clears both flags. If clr_err and a new error occur in the same cycle, the error wins (the flag stays 1).
- wait_cnt is $clog2(MAX_WAIT+1) bits wide and saturates; it never wraps.

Decomposition:
- Package rom_ctrl_pkg holds the state enum (IDLE, WAIT, HOLD) and the FILL default constant.
- One sub-module, rom_sel_decode, is combinational. It maps CE_b and OE_b to sel_valid, chip_idx and multi_sel. It is reused by the future RAM-socket controller.

Test Plan:
1. NUM_CHIPS=4. CE_b=4'b1101, OE_b=0, A=14'h0123, mem_ack 3 cycles after mem_req with rdata 8'hA5 -> mem_addr=16'h4123, rdy=1 and D=8'hA5 on the cycle after ack.
2. Deselect, then repeat the same read -> no mem_req, rdy=1 one cycle after select, D=8'hA5. Repeat with inval pulsed in the select cycle -> mem_req is issued (miss).
3. CE_b=4'b0011 with OE_b=0 -> no mem_req, D_oe=0, multi_sel_err=1. clr_err pulse -> flag returns to 0.
4. Miss with mem_ack never asserted -> mem_req drops after exactly 15 cycles; rdy=1 with D=8'hFF; timeout_err=1. A repeat read misses (cache not filled).
5. In HOLD, change A from 14'h0010 to 14'h0011 -> rdy low for 1 cycle, then a new miss is issued with mem_addr updated.
6. Assert rst_b=0 mid-WAIT -> mem_req, rdy and D_oe drop asynchronously. A following mem_ack after reset release is ignored and the state is IDLE.

Source files
------------

// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the ROM-socket emulation controllers.
//   state_e      : controller FSM states (idle, waiting on memory, holding data)
//   FILL_DEFAULT : open-bus value returned when a memory access times out
package rom_ctrl_pkg;

  localparam int unsigned FILL_DEFAULT_W = 64;

  // All ones; callers truncate to their data width.
  localparam logic [FILL_DEFAULT_W-1:0] FILL_DEFAULT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/rom_sel_decode.sv
// Combinational socket-select decoder shared by the ROM and RAM socket controllers.
// Ports:
//   CE_b        : per-chip enables, active low
//   OE_b        : output enable, active low
//   sel_valid_c : OE_b low and exactly one CE_b bit low
//   chip_idx_c  : index of the low CE_b bit (meaningful only with sel_valid_c)
//   multi_sel_c : OE_b low and two or more CE_b bits low
module rom_sel_decode #(
  parameter int unsigned NUM_CHIPS = 4,
  parameter int unsigned CHIP_W    = $clog2(NUM_CHIPS)
) (
  input  logic [NUM_CHIPS-1:0] CE_b,
  input  logic                 OE_b,
  output logic                 sel_valid_c,
  output logic [CHIP_W-1:0]    chip_idx_c,
  output logic                 multi_sel_c
);

  logic any_low;
  logic many_low;

  // Scan the enables: remember the last low bit and whether a second one was seen.
  always_comb begin
    any_low    = 1'b0;
    many_low   = 1'b0;
    chip_idx_c = '0;
    for (int i = 0; i < int'(NUM_CHIPS); i++) begin
      if (!CE_b[i]) begin
        if (any_low) begin
          many_low = 1'b1;
        end
        any_low    = 1'b1;
        chip_idx_c = CHIP_W'(i);
      end
    end
  end

  assign sel_valid_c = ~OE_b & any_low & ~many_low;
  assign multi_sel_c = ~OE_b & many_low;

endmodule

// File: rtl/rom_bank_ctrl.sv
// Emulates NUM_CHIPS EPROM sockets on one synchronous req/ack memory port,
// with CPU wait states, a one-entry last-read cache, access timeout and
// sticky error flags.
// Ports:
//   clk, rst_b     : clock, asynchronous active-low reset
//   A, CE_b, OE_b  : CPU address within chip, per-chip enables, output enable
//   inval          : invalidate the cached entry
//   clr_err        : clear sticky error flags
//   D, D_oe, rdy   : read data, tristate drive enable, data valid to CPU
//   mem_req        : level read request to the board memory arbiter
//   mem_addr       : {chip_idx, A} of the outstanding request
//   mem_ack        : single-cycle acknowledge, mem_rdata valid in that cycle
//   mem_rdata      : external read data
//   multi_sel_err  : sticky, several sockets selected while OE_b low
//   timeout_err    : sticky, an access got no acknowledge in time
module rom_bank_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CHIPS = 4,
  parameter int unsigned MAX_WAIT  = 15,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(FILL_DEFAULT),
  localparam int unsigned CHIP_W   = $clog2(NUM_CHIPS)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [ADDR_W-1:0]        A,
  input  logic [NUM_CHIPS-1:0]     CE_b,
  input  logic                     OE_b,
  input  logic                     inval,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        D,
  output logic                     D_oe,
  output logic                     rdy,
  output logic                     mem_req,
  output logic [CHIP_W+ADDR_W-1:0] mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     multi_sel_err,
  output logic                     timeout_err
);

  localparam int unsigned AW    = CHIP_W + ADDR_W;
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic              sel_valid_c;
  logic [CHIP_W-1:0] chip_idx_c;
  logic              multi_sel_c;
  logic [AW-1:0]     sel_addr_c;
  logic              hit_c;

  state_e            state_q,       state_d;
  logic [CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;
  logic [AW-1:0]     cur_addr_q,    cur_addr_d;
  logic              cache_valid_q, cache_valid_d;
  logic [AW-1:0]     cache_tag_q,   cache_tag_d;
  logic [DATA_W-1:0] cache_data_q,  cache_data_d;
  logic [DATA_W-1:0] data_d;
  logic              mem_req_d;
  logic [AW-1:0]     mem_addr_d;
  logic              multi_d;
  logic              timeout_d;
  logic              rdy_d;

  rom_sel_decode #(
    .NUM_CHIPS (NUM_CHIPS),
    .CHIP_W    (CHIP_W)
  ) u_sel_decode (
    .CE_b        (CE_b),
    .OE_b        (OE_b),
    .sel_valid_c (sel_valid_c),
    .chip_idx_c  (chip_idx_c),
    .multi_sel_c (multi_sel_c)
  );

  assign sel_addr_c = {chip_idx_c, A};
  assign hit_c      = cache_valid_q && (cache_tag_q == sel_addr_c);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cur_addr_d    = cur_addr_q;
    data_d        = D;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    // inval beats a same-cycle fill: the ROM image may have changed under the fetch.
    cache_valid_d = cache_valid_q & ~inval;
    // A new error in the clear cycle keeps the flag set.
    multi_d       = (multi_sel_err & ~clr_err) | multi_sel_c;
    timeout_d     = timeout_err & ~clr_err;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid_c) begin
          cur_addr_d = sel_addr_c;
          if (hit_c && !inval) begin
            data_d  = cache_data_q;
            state_d = ST_HOLD;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = sel_addr_c;
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (mem_ack) begin
          data_d    = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_HOLD;
          if (!inval) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = mem_addr;
            cache_data_d  = mem_rdata;
          end
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          data_d    = FILL;
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        // Any change of selection ends the cycle; a new access starts from idle.
        if (!sel_valid_c || (sel_addr_c != cur_addr_q)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy_d = (state_d == ST_HOLD);
  end

  // State, cache and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      cur_addr_q    <= '0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      D             <= '0;
      D_oe          <= 1'b0;
      rdy           <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      multi_sel_err <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cur_addr_q    <= cur_addr_d;
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      D             <= rdy_d ? data_d : '0;
      D_oe          <= rdy_d;
      rdy           <= rdy_d;
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
      multi_sel_err <= multi_d;
      timeout_err   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rom_bank_ctrl.sv
// Self-checking bench for rom_bank_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_rom_bank_ctrl;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NC       = 4;
  localparam int unsigned CHIP_W   = 2;
  localparam int unsigned AW       = CHIP_W + ADDR_W;
  localparam int unsigned MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [ADDR_W-1:0] A;
  logic [NC-1:0]     CE_b;
  logic              OE_b;
  logic              inval;
  logic              clr_err;
  logic [DATA_W-1:0] D;
  logic              D_oe;
  logic              rdy;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              multi_sel_err;
  logic              timeout_err;

  rom_bank_ctrl dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .A             (A),
    .CE_b          (CE_b),
    .OE_b          (OE_b),
    .inval         (inval),
    .clr_err       (clr_err),
    .D             (D),
    .D_oe          (D_oe),
    .rdy           (rdy),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .multi_sel_err (multi_sel_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A CPU read is either being fetched from memory, being presented, or absent.
  bit                m_fetch, m_show;
  int                m_age;
  logic [AW-1:0]     m_key;
  bit                c_ok;
  logic [AW-1:0]     c_key;
  logic [DATA_W-1:0] c_val;
  logic              e_rdy, e_req, e_multi, e_to;
  logic [DATA_W-1:0] e_d;
  logic [AW-1:0]     e_addr;
  int                s_lows, s_idx;
  bit                s_ok, s_multi;
  logic [AW-1:0]     s_key;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_fetch = 0; m_show = 0; m_age = 0; m_key = '0;
      c_ok = 0; c_key = '0; c_val = '0;
      e_rdy = 0; e_req = 0; e_multi = 0; e_to = 0; e_d = '0; e_addr = '0;
    end else begin
      s_lows = 0; s_idx = 0;
      for (int i = 0; i < int'(NC); i++) if (!CE_b[i]) begin s_lows++; s_idx = i; end
      s_ok    = !OE_b && (s_lows == 1);
      s_multi = !OE_b && (s_lows > 1);
      s_key   = AW'(s_idx * (1 << ADDR_W) + int'(A));
      e_multi = (e_multi && !clr_err) || s_multi;
      e_to    = e_to && !clr_err;
      if (m_fetch) begin
        m_age++;
        if (mem_ack) begin
          m_fetch = 0; m_show = 1; e_d = mem_rdata;
          c_ok = 1; c_key = e_addr; c_val = mem_rdata;
        end else if (m_age == int'(MAX_WAIT)) begin
          m_fetch = 0; m_show = 1; e_d = 8'hFF; e_to = 1;
        end
      end else if (m_show) begin
        if (!s_ok || s_key != m_key) begin m_show = 0; e_d = '0; end
      end else if (s_ok) begin
        m_key = s_key;
        if (c_ok && c_key == s_key && !inval) begin
          m_show = 1; e_d = c_val;
        end else begin
          m_fetch = 1; m_age = 0; e_addr = s_key;
        end
      end
      if (inval) c_ok = 0;
      e_req = m_fetch;
      e_rdy = m_show;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rdy",           32'(rdy),           32'(e_rdy));
      chk("D_oe",          32'(D_oe),          32'(e_rdy));
      chk("D",             32'(D),             32'(e_d));
      chk("mem_req",       32'(mem_req),       32'(e_req));
      chk("mem_addr",      32'(mem_addr),      32'(e_addr));
      chk("multi_sel_err", 32'(multi_sel_err), 32'(e_multi));
      chk("timeout_err",   32'(timeout_err),   32'(e_to));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sel(input logic [NC-1:0] ce, input logic [ADDR_W-1:0] a);
    CE_b = ce; OE_b = 1'b0; A = a;
  endtask

  task automatic desel();
    CE_b = '1; OE_b = 1'b1;
  endtask

  logic [ADDR_W-1:0] atab [4] = '{14'h0010, 14'h0011, 14'h3FFF, 14'h0123};
  int                n_req, hold, kind;
  bit                ack_on;

  initial begin
    rst_b = 1'b0; A = '0; CE_b = '1; OE_b = 1'b1; inval = 1'b0; clr_err = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    chk_on = 1'b1;
    chk("reset rdy", 32'(rdy), 32'd0);
    chk("reset D_oe", 32'(D_oe), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset errs", 32'({multi_sel_err, timeout_err}), 32'd0);

    // 1: miss on chip 1, ack three cycles after the request
    sel(4'b1101, 14'h0123);
    step();
    chk("t1 mem_req", 32'(mem_req), 32'd1);
    chk("t1 mem_addr", 32'(mem_addr), 32'h4123);
    step(); step();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    step();
    mem_ack = 1'b0;
    chk("t1 rdy", 32'(rdy), 32'd1);
    chk("t1 D", 32'(D), 32'hA5);
    chk("t1 req drop", 32'(mem_req), 32'd0);

    // 2: hit after deselect, then inval forces a miss
    desel(); step();
    chk("t2 deselect rdy", 32'(rdy), 32'd0);
    sel(4'b1101, 14'h0123); step();
    chk("t2 hit rdy", 32'(rdy), 32'd1);
    chk("t2 hit D", 32'(D), 32'hA5);
    chk("t2 hit no req", 32'(mem_req), 32'd0);
    desel(); step();
    sel(4'b1101, 14'h0123); inval = 1'b1; step();
    inval = 1'b0;
    chk("t2 inval miss", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h5A; step();
    mem_ack = 1'b0;
    chk("t2 refill D", 32'(D), 32'h5A);
    desel(); step();

    // 3: multi-select error and clear
    CE_b = 4'b0011; OE_b = 1'b0; step();
    chk("t3 no req", 32'(mem_req), 32'd0);
    chk("t3 D_oe", 32'(D_oe), 32'd0);
    chk("t3 flag", 32'(multi_sel_err), 32'd1);
    desel(); clr_err = 1'b1; step();
    clr_err = 1'b0;
    chk("t3 clear", 32'(multi_sel_err), 32'd0);

    // 4: timeout after exactly MAX_WAIT request cycles
    sel(4'b1011, 14'h0200); step();
    n_req = mem_req ? 1 : 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      step();
      if (mem_req) n_req++;
    end
    chk("t4 req cycles", 32'(n_req), 32'd15);
    chk("t4 rdy", 32'(rdy), 32'd1);
    chk("t4 fill", 32'(D), 32'hFF);
    chk("t4 timeout_err", 32'(timeout_err), 32'd1);
    desel(); step();
    sel(4'b1011, 14'h0200); step();
    chk("t4 repeat misses", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h3C; step();
    mem_ack = 1'b0; desel(); clr_err = 1'b1; step();
    clr_err = 1'b0;

    // 5: address change while holding
    sel(4'b1110, 14'h0010); step();
    mem_ack = 1'b1; mem_rdata = 8'h11; step();
    mem_ack = 1'b0;
    chk("t5 hold", 32'(rdy), 32'd1);
    A = 14'h0011; step();
    chk("t5 rdy gap", 32'(rdy), 32'd0);
    step();
    chk("t5 new req", 32'(mem_req), 32'd1);
    chk("t5 new addr", 32'(mem_addr), 32'h0011);
    mem_ack = 1'b1; mem_rdata = 8'h22; step();
    mem_ack = 1'b0; desel(); step();

    // 6: reset in the middle of a wait
    sel(4'b0111, 14'h3FFF); step();
    chk("t6 req", 32'(mem_req), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("t6 async req", 32'(mem_req), 32'd0);
    chk("t6 async rdy", 32'(rdy), 32'd0);
    chk("t6 async D_oe", 32'(D_oe), 32'd0);
    desel();
    step();
    rst_b = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    chk("t6 late ack rdy", 32'(rdy), 32'd0);
    chk("t6 late ack req", 32'(mem_req), 32'd0);
    sel(4'b1101, 14'h0123); step();
    chk("t6 cache cleared", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h99; step();
    mem_ack = 1'b0; desel(); step();

    // Randomized traffic; the model checks every cycle.
    for (int it = 0; it < 400; it++) begin
      hold   = $urandom_range(1, 8);
      kind   = $urandom_range(0, 9);
      ack_on = ($urandom_range(0, 7) != 0);
      if (kind < 7)      CE_b = ~(4'b0001 << $urandom_range(0, 3));
      else if (kind < 8) CE_b = 4'hF;
      else               CE_b = 4'($urandom);
      OE_b = ($urandom_range(0, 7) == 0);
      A    = atab[$urandom_range(0, 3)];
      for (int c = 0; c < hold; c++) begin
        inval   = ($urandom_range(0, 19) == 0);
        clr_err = ($urandom_range(0, 19) == 0);
        if (mem_req) mem_ack = ack_on && ($urandom_range(0, 2) == 0);
        else         mem_ack = ($urandom_range(0, 15) == 0);
        mem_rdata = 8'($urandom);
        step();
      end
    end
    inval = 1'b0; clr_err = 1'b0; mem_ack = 1'b0; desel();
    step(); step();
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
